// File: rtl/cf_pkg.sv
// Shared constants and types for the cf_approx_median 3x3 filter core.
package cf_pkg;

  localparam int DW = 8;

  typedef enum logic [1:0] {
    MODE_MED = 2'd0,
    MODE_MIN = 2'd1,
    MODE_MAX = 2'd2,
    MODE_BYP = 2'd3
  } mode_e;

endpackage : cf_pkg

// File: rtl/sort3.sv
// Combinational three-input unsigned sorter: returns min, median and max.
module sort3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_min,
  output logic [W-1:0] o_med,
  output logic [W-1:0] o_max
);

  logic [W-1:0] w_lo;
  logic [W-1:0] w_hi;

  // Order a/b first, then place c relative to that pair; ties resolve to equal values.
  assign w_lo  = (i_a > i_b) ? i_b : i_a;
  assign w_hi  = (i_a > i_b) ? i_a : i_b;
  assign o_min = (i_c < w_lo) ? i_c : w_lo;
  assign o_max = (i_c > w_hi) ? i_c : w_hi;
  assign o_med = (i_c < w_lo) ? w_lo : ((i_c > w_hi) ? w_hi : i_c);

endmodule : sort3

// File: rtl/cf_approx_median.sv
// Two-stage 3x3 approximate median / min / max / bypass filter, one window per cycle.
module cf_approx_median
  import cf_pkg::*;
#(
  parameter int DW = cf_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  input  logic [DW-1:0] i2,
  input  logic [DW-1:0] i3,
  input  logic [DW-1:0] i4,
  input  logic [DW-1:0] i5,
  input  logic [DW-1:0] i6,
  input  logic [DW-1:0] i7,
  input  logic [DW-1:0] i8,
  input  logic [1:0]    s,
  output logic [DW-1:0] y,
  output logic          out_valid
);

  logic [DW-1:0] w_row_min [3];
  logic [DW-1:0] w_row_med [3];
  logic [DW-1:0] w_row_max [3];

  logic [DW-1:0] r_row_min [3];
  logic [DW-1:0] r_row_med [3];
  logic [DW-1:0] r_row_max [3];
  logic [DW-1:0] r_ctr;
  mode_e         r_mode;
  logic          r_v1;

  logic [DW-1:0] w_med_med;
  logic [DW-1:0] w_unused_med_lo;
  logic [DW-1:0] w_unused_med_hi;
  logic [DW-1:0] w_min_all;
  logic [DW-1:0] w_max_all;
  logic [DW-1:0] w_sel;

  sort3 #(.W(DW)) u_row0 (
    .i_a(i0), .i_b(i1), .i_c(i2),
    .o_min(w_row_min[0]), .o_med(w_row_med[0]), .o_max(w_row_max[0])
  );

  sort3 #(.W(DW)) u_row1 (
    .i_a(i3), .i_b(i4), .i_c(i5),
    .o_min(w_row_min[1]), .o_med(w_row_med[1]), .o_max(w_row_max[1])
  );

  sort3 #(.W(DW)) u_row2 (
    .i_a(i6), .i_b(i7), .i_c(i8),
    .o_min(w_row_min[2]), .o_med(w_row_med[2]), .o_max(w_row_max[2])
  );

  // Stage 1: data registers only load on a valid window; the valid bit tracks every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the stage-1 arrays are a handful of flops, not a RAM, so resetting them is cheap and keeps the pipeline deterministic.
      for (int k = 0; k < 3; k++) begin
        r_row_min[k] <= '0;
        r_row_med[k] <= '0;
        r_row_max[k] <= '0;
      end
      r_ctr  <= '0;
      r_mode <= MODE_MED;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < 3; k++) begin
          r_row_min[k] <= w_row_min[k];
          r_row_med[k] <= w_row_med[k];
          r_row_max[k] <= w_row_max[k];
        end
        r_ctr  <= i4;
        r_mode <= mode_e'(s);
      end
    end
  end

  sort3 #(.W(DW)) u_med (
    .i_a(r_row_med[0]), .i_b(r_row_med[1]), .i_c(r_row_med[2]),
    .o_min(w_unused_med_lo), .o_med(w_med_med), .o_max(w_unused_med_hi)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_min_all = r_row_min[0];
    w_max_all = r_row_max[0];
    w_sel     = r_ctr;
    for (int k = 1; k < 3; k++) begin
      if (r_row_min[k] < w_min_all) w_min_all = r_row_min[k];
      if (r_row_max[k] > w_max_all) w_max_all = r_row_max[k];
    end
    unique case (r_mode)
      MODE_MED: w_sel = w_med_med;
      MODE_MIN: w_sel = w_min_all;
      MODE_MAX: w_sel = w_max_all;
      MODE_BYP: w_sel = r_ctr;
      default:  w_sel = r_ctr;
    endcase
  end

  // Stage 2: y holds its last result across bubbles; out_valid follows the stage-1 valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= r_v1;
      if (r_v1) y <= w_sel;
    end
  end

endmodule : cf_approx_median

// File: tb/tb_cf_approx_median.sv
// Self-checking bench for cf_approx_median: directed table, bubbles, reset and random windows.
module tb_cf_approx_median;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] win [9];
  logic [1:0] s;
  logic [7:0] y;
  logic       out_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] w [9];
    logic [1:0] m;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    bit         v;
    logic [7:0] y;
  } exp_t;

  exp_t       q[$];
  logic [7:0] last_y;
  vec_t       tbl [8];
  logic [7:0] wtmp [9];

  cf_approx_median dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .i0(win[0]), .i1(win[1]), .i2(win[2]),
    .i3(win[3]), .i4(win[4]), .i5(win[5]),
    .i6(win[6]), .i7(win[7]), .i8(win[8]),
    .s(s), .y(y), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: row medians by sum minus extremes, global min/max over all nine pixels.
  function automatic logic [7:0] ref_out(input logic [7:0] w [9], input logic [1:0] m);
    int med [3];
    int a, b, c, lo, hi, mn, mx;
    mn = 255;
    mx = 0;
    for (int r = 0; r < 3; r++) begin
      a = w[3*r]; b = w[3*r+1]; c = w[3*r+2];
      lo = (a < b) ? a : b; lo = (c < lo) ? c : lo;
      hi = (a > b) ? a : b; hi = (c > hi) ? c : hi;
      med[r] = a + b + c - lo - hi;
    end
    for (int i = 0; i < 9; i++) begin
      if (w[i] < mn) mn = w[i];
      if (w[i] > mx) mx = w[i];
    end
    case (m)
      2'd0: begin
        lo = (med[0] < med[1]) ? med[0] : med[1]; lo = (med[2] < lo) ? med[2] : lo;
        hi = (med[0] > med[1]) ? med[0] : med[1]; hi = (med[2] > hi) ? med[2] : hi;
        return 8'(med[0] + med[1] + med[2] - lo - hi);
      end
      2'd1:    return 8'(mn);
      2'd2:    return 8'(mx);
      default: return w[4];
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; after the edge, compare the result of the previous cycle's window.
  task automatic step(input string tag, input bit v, input logic [7:0] w [9], input logic [1:0] m);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    for (int i = 0; i < 9; i++) win[i] = w[i];
    s = m;
    @(posedge clk);
    e.v = v;
    e.y = ref_out(w, m);
    q.push_back(e);
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      check({tag, "_out_valid"}, {7'd0, out_valid}, {7'd0, e.v});
      if (e.v) begin
        check({tag, "_y"}, y, e.y);
        last_y = e.y;
      end else begin
        check({tag, "_y_hold"}, y, last_y);
      end
    end
  endtask

  task automatic model_reset();
    exp_t e;
    q.delete();
    e.v = 1'b0;
    e.y = '0;
    q.push_back(e);
    last_y = '0;
  endtask

  task automatic rand_win(output logic [7:0] w [9]);
    for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    tbl[0] = '{w: '{10, 20, 30, 40, 50, 60, 70, 80, 90}, m: 2'd0, exp: 8'd50};
    tbl[1] = '{w: '{10, 20, 30, 40, 50, 60, 70, 80, 90}, m: 2'd1, exp: 8'd10};
    tbl[2] = '{w: '{10, 20, 30, 40, 50, 60, 70, 80, 90}, m: 2'd2, exp: 8'd90};
    tbl[3] = '{w: '{10, 20, 30, 40, 50, 60, 70, 80, 90}, m: 2'd3, exp: 8'd50};
    tbl[4] = '{w: '{5, 200, 7, 255, 0, 128, 3, 3, 3},     m: 2'd0, exp: 8'd7};
    tbl[5] = '{w: '{5, 200, 7, 255, 0, 128, 3, 3, 3},     m: 2'd1, exp: 8'd0};
    tbl[6] = '{w: '{5, 200, 7, 255, 0, 128, 3, 3, 3},     m: 2'd2, exp: 8'd255};
    tbl[7] = '{w: '{5, 200, 7, 255, 0, 128, 3, 3, 3},     m: 2'd3, exp: 8'd0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    s        = 2'd0;
    for (int i = 0; i < 9; i++) win[i] = '0;
    #1;
    check("reset_y", y, 8'd0);
    check("reset_out_valid", {7'd0, out_valid}, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Directed table: each window isolated by a bubble.
    for (int k = 0; k < 8; k++) begin
      step("tbl", 1'b1, tbl[k].w, tbl[k].m);
      step("tbl_gap", 1'b0, tbl[k].w, 2'd0);
      check($sformatf("tbl%0d_exp", k), y, tbl[k].exp);
    end

    // Streaming: four back-to-back windows with modes 0..3.
    for (int k = 0; k < 4; k++) begin
      rand_win(wtmp);
      step("stream", 1'b1, wtmp, 2'(k));
    end
    step("stream_tail", 1'b0, wtmp, 2'd0);

    // Bubble: valid, invalid, valid; y must hold across the gap.
    rand_win(wtmp);
    step("bubble", 1'b1, wtmp, 2'd2);
    step("bubble", 1'b0, wtmp, 2'd1);
    rand_win(wtmp);
    step("bubble", 1'b1, wtmp, 2'd1);
    step("bubble", 1'b0, wtmp, 2'd0);
    step("bubble", 1'b0, wtmp, 2'd0);

    // Mid-stream reset with windows in flight.
    for (int k = 0; k < 3; k++) begin
      rand_win(wtmp);
      step("pre_rst", 1'b1, wtmp, 2'(k));
    end
    rst_n = 1'b0;
    #1;
    check("midrst_y", y, 8'd0);
    check("midrst_out_valid", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step("post_rst", 1'b0, wtmp, 2'd0);
    rand_win(wtmp);
    step("post_rst", 1'b1, wtmp, 2'd2);
    step("post_rst", 1'b0, wtmp, 2'd0);

    // Random windows, modes and valid pattern.
    for (int n = 0; n < 1000; n++) begin
      rand_win(wtmp);
      step("rand", ($urandom_range(0, 3) != 0), wtmp, 2'($urandom_range(0, 3)));
    end
    step("flush", 1'b0, wtmp, 2'd0);
    step("flush", 1'b0, wtmp, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cf_approx_median

// File: doc/cf_approx_median.md
Name: cf_approx_median

Overview:
- Pipelined 3x3 approximate median filter core for 8-bit pixel windows.
- Takes a full 3x3 window each cycle and produces one 8-bit result per window; a 2-bit mode input selects the result.
- Selectable results: approximate median (median of row medians), window minimum, window maximum, or centre-pixel bypass.
- Sits between the line-buffer/window generator and the pixel output stage of the image pipeline.

Parameters:
- DW, 8, pixel data width in bits; all window inputs and y share this width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  window inputs and s are valid this cycle.
- i0..i8  input  DW each  window pixels, row-major: row0={i0,i1,i2}, row1={i3,i4,i5}, row2={i6,i7,i8}; i4 is the centre pixel.
- s  input  2  mode select, sampled with the window.
- y  output  DW  filter result.
- out_valid  output  1  y holds a new result this cycle.

Behaviour:
- Reset: while rst_n=0, asynchronously force y=0, out_valid=0, and all pipeline registers and valid bits to 0.
- Comparisons are unsigned. Ties are legal; with equal values any tie order gives the same value.
- Stage 1 (edge N, in_valid=1):
  - for each row, register the row min, median and max;
  - register i4, s and a stage-1 valid bit.
- Stage 2 (edge N+1): register y and out_valid from stage-1 data. y is selected by the staged s:
  - s=0: median of the three row medians (approximate median);
  - s=1: minimum of the three row mins (exact window minimum);
  - s=2: maximum of the three row maxes (exact window maximum);
  - s=3: i4 (bypass).
- Latency: a window sampled at edge N gives y and out_valid=1 after edge N+1, visible during cycle N+2.
- Throughput: one window per cycle, no stalls and no backpressure.
- in_valid=0: the stage valid bit clears. After edge N+1, out_valid=0 and y holds its previous value; data registers are not updated.
- Back-to-back valids produce back-to-back results in order.
- Each result uses the s sampled with its own window. A mode change applies per window with no cross-window mixing.
- Reset asserted mid-stream discards all in-flight windows. The first result after release is from a window sampled after release.
- No overflow possible: only compare/select, no arithmetic.

Decomposition:
- Package cf_pkg:
  - DW constant;
  - 2-bit mode enum: MODE_MED=0, MODE_MIN=1, MODE_MAX=2, MODE_BYP=3.
- Sub-module sort3: purely combinational 3-input sorter with outputs min, med and max.
  - Instantiated three times in stage 1 (one per row).
  - Instantiated once in stage 2 on the row medians; its med output is used.
- Min and max of three are also derived via sort3 instances or inline compares.

Test Plan:
- Reset: assert rst_n=0 mid-stream with windows in flight -> y=0 and out_valid=0 immediately. After release, no out_valid until 2 edges after the first new in_valid.
- Ordered window 10,20,30 / 40,50,60 / 70,80,90 -> 2 cycles later:
  - s=0 -> y=50;
  - s=1 -> y=10;
  - s=2 -> y=90;
  - s=3 -> y=50.
- Irregular window 5,200,7 / 255,0,128 / 3,3,3 -> row medians 7,128,3:
  - s=0 -> y=7;
  - s=1 -> y=0;
  - s=2 -> y=255;
  - s=3 -> y=0.
- Streaming: 4 consecutive valid windows with s cycling 0,1,2,3 -> 4 consecutive out_valid results, each matching its own window and mode, correct order.
- Bubble: valid, invalid, valid sequence -> out_valid pattern 1,0,1 with y held unchanged during the 0 cycle.
- Random: 1000 random windows and modes checked against a reference model computing row medians, min, max and centre -> zero mismatches.
